// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and its driver: serial line, frame
// configuration, baud enable and the received-character status.
interface uart_rx_if;
  logic       ce_16;
  logic       ser_in;
  logic       parity_en;
  logic       parity_odd;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  modport slave (
    input  ce_16, ser_in, parity_en, parity_odd,
    output rx_data, new_rx_data, frame_err, parity_err, rx_busy
  );

  modport master (
    output ce_16, ser_in, parity_en, parity_odd,
    input  rx_data, new_rx_data, frame_err, parity_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 8 data bits LSB first, optional even/odd
// parity, one stop bit; one-clock new_rx_data strobe per completed frame.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  uart_rx_if.slave   bus
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [SYNC_N-1:0] sync_q;
  logic              rx_s;
  logic              rx_last_q, rx_last_d;
  logic [3:0]        cnt16_q, cnt16_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              pen_q, pen_d;
  logic              podd_q, podd_d;
  logic              perr_frame_q, perr_frame_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              new_q, new_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;

  function automatic logic parity_mismatch(input logic [7:0] data,
                                           input logic       pbit,
                                           input logic       odd);
    return ((^data) ^ pbit) != odd;
  endfunction

  // Input synchronizer; idle-high so reset never looks like a start edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_N-2:0], bus.ser_in};
  end

  assign rx_s = sync_q[SYNC_N-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rx_last_q    <= 1'b1;
      cnt16_q      <= '0;
      bit_cnt_q    <= '0;
      rx_data_q    <= '0;
      new_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_last_q    <= rx_last_d;
      cnt16_q      <= cnt16_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_data_q    <= rx_data_d;
      new_q        <= new_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Per-frame working storage is always written before it is consumed
  always_ff @(posedge clock) begin
    shift_q      <= shift_d;
    pen_q        <= pen_d;
    podd_q       <= podd_d;
    perr_frame_q <= perr_frame_d;
  end

  always_comb begin
    state_d      = state_q;
    rx_last_d    = rx_last_q;
    cnt16_d      = cnt16_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    pen_d        = pen_q;
    podd_d       = podd_q;
    perr_frame_d = perr_frame_q;
    rx_data_d    = rx_data_q;
    new_d        = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;

    if (bus.ce_16) begin
      rx_last_d = rx_s;
      cnt16_d   = cnt16_q + 4'd1;
      case (state_q)
        S_IDLE: begin
          cnt16_d = cnt16_q;
          // Only a genuine high-to-low transition starts a frame
          if (rx_last_q && !rx_s) begin
            state_d      = S_START;
            cnt16_d      = '0;
            pen_d        = bus.parity_en;
            podd_d       = bus.parity_odd;
            perr_frame_d = 1'b0;
          end
        end
        S_START: begin
          if (cnt16_q == 4'd7) begin
            if (!rx_s) begin
              state_d   = S_DATA;
              cnt16_d   = '0;
              bit_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (cnt16_q == 4'd15) begin
            shift_d[bit_cnt_q] = rx_s;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = pen_q ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (cnt16_q == 4'd15) begin
            perr_frame_d = parity_mismatch(shift_q, rx_s, podd_q);
            state_d      = S_STOP;
          end
        end
        S_STOP: begin
          // Leaving at mid stop bit lets a back-to-back start edge be caught
          if (cnt16_q == 4'd15) begin
            rx_data_d    = shift_q;
            frame_err_d  = !rx_s;
            parity_err_d = pen_q & perr_frame_q;
            new_d        = 1'b1;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.new_rx_data = new_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx;
  logic clock = 1'b0;
  logic reset;
  int   ce_div = 4;
  int   tests  = 0;
  int   fails  = 0;

  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];

  uart_rx_if bus();

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // 16x enable: one clock high every ce_div clocks, changed away from the active edge
  initial begin
    int c;
    c = 0;
    bus.ce_16 = 1'b0;
    forever begin
      @(negedge clock);
      if (c >= ce_div - 1) begin
        c = 0;
        bus.ce_16 = 1'b1;
      end else begin
        c++;
        bus.ce_16 = 1'b0;
      end
    end
  end

  // Capture every strobe; a two-clock strobe shows up as two captures
  initial begin
    forever begin
      @(negedge clock);
      if (bus.new_rx_data === 1'b1)
        got_q.push_back({bus.rx_data, bus.frame_err, bus.parity_err});
    end
  end

  // Reference: what a frame with these line bits must report
  function automatic logic [9:0] model_frame(input logic [7:0] d, input bit pen,
                                             input bit podd, input bit pbit, input bit stop);
    int ones;
    bit perr;
    ones = $countones(d) + ((pen && pbit) ? 1 : 0);
    perr = pen && ((ones % 2) != (podd ? 1 : 0));
    return {d, ~stop, perr};
  endfunction

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      while (bus.ce_16 !== 1'b1) @(posedge clock);
    end
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    bus.ser_in = b;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd,
                            input bit pbit, input bit stop, input bit scramble);
    bus.parity_en  = pen;
    bus.parity_odd = podd;
    drive_bit(1'b0, 12);
    if (scramble) begin
      bus.parity_en  = 1'($urandom);
      bus.parity_odd = 1'($urandom);
    end
    drive_bit(1'b0, 4);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
    if (pen) drive_bit(pbit, 16);
    drive_bit(stop, 16);
    exp_q.push_back(model_frame(d, pen, podd, pbit, stop));
  endtask

  task automatic wait_frames(input int n, output bit ok);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 20000) begin
      @(negedge clock);
      cyc++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    bus.ser_in = 1'b1;
    bus.parity_en = 1'b0;
    bus.parity_odd = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (4) @(negedge clock);
    tests++;
    if ({bus.rx_data, bus.new_rx_data, bus.frame_err, bus.parity_err, bus.rx_busy} !== 12'h000) begin
      fails++;
      $display("FAIL reset_in: got %h expected 000",
               {bus.rx_data, bus.new_rx_data, bus.frame_err, bus.parity_err, bus.rx_busy});
    end
    reset = 1'b0;
    repeat (20) @(negedge clock);
    tests++;
    if ({bus.rx_data, bus.new_rx_data, bus.frame_err, bus.parity_err, bus.rx_busy} !== 12'h000) begin
      fails++;
      $display("FAIL reset_after: got %h expected 000",
               {bus.rx_data, bus.new_rx_data, bus.frame_err, bus.parity_err, bus.rx_busy});
    end
  endtask

  task automatic test_8n1();
    int n; bit ok; logic [9:0] e, g;
    ce_div = 4;
    drive_bit(1'b1, 4);
    send_frame(8'h55, 0, 0, 0, 1, 0);
    drive_bit(1'b1, 16);
    n = exp_q.size();
    wait_frames(n, ok);
    tests++;
    if (!ok || got_q.size() != n) begin
      fails++;
      $display("FAIL 8n1_count: got %0d pulses expected %0d", got_q.size(), n);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL 8n1_frame: got d=%h fe=%b pe=%b expected d=%h fe=%b pe=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]);
      end
    end
    tests++;
    if (bus.rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL 8n1_busy: got %b expected 0", bus.rx_busy);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_false_start();
    int n; bit ok; logic [9:0] e, g;
    ce_div = 4;
    drive_bit(1'b0, 5);
    tests++;
    if (bus.rx_busy !== 1'b1) begin
      fails++;
      $display("FAIL false_start_busy_hi: got %b expected 1", bus.rx_busy);
    end
    drive_bit(1'b1, 8);
    tests++;
    if (bus.rx_busy !== 1'b0 || got_q.size() != 0) begin
      fails++;
      $display("FAIL false_start_abort: got busy=%b pulses=%0d expected busy=0 pulses=0", bus.rx_busy, got_q.size());
    end
    drive_bit(1'b1, 16);
    send_frame(8'hC3, 0, 0, 0, 1, 0);
    drive_bit(1'b1, 16);
    n = exp_q.size();
    wait_frames(n, ok);
    tests++;
    if (!ok || got_q.size() != n) begin
      fails++;
      $display("FAIL false_start_count: got %0d pulses expected %0d", got_q.size(), n);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL false_start_frame: got d=%h fe=%b pe=%b expected d=%h fe=%b pe=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_framing_break();
    int n; bit ok; logic [9:0] e, g;
    ce_div = 1;
    send_frame(8'hA3, 0, 0, 0, 0, 0);
    drive_bit(1'b0, 640);
    tests++;
    if (got_q.size() != 1 || bus.rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL break_quiet: got pulses=%0d busy=%b expected pulses=1 busy=0", got_q.size(), bus.rx_busy);
    end
    drive_bit(1'b1, 32);
    send_frame(8'h01, 0, 0, 0, 1, 0);
    drive_bit(1'b1, 16);
    n = exp_q.size();
    wait_frames(n, ok);
    tests++;
    if (!ok || got_q.size() != n) begin
      fails++;
      $display("FAIL break_count: got %0d pulses expected %0d", got_q.size(), n);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL break_frame: got d=%h fe=%b pe=%b expected d=%h fe=%b pe=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_parity();
    int n; bit ok; logic [9:0] e, g;
    ce_div = 2;
    send_frame(8'h07, 1, 0, 1, 1, 0);
    drive_bit(1'b1, 4);
    send_frame(8'h07, 1, 0, 0, 1, 0);
    drive_bit(1'b1, 4);
    send_frame(8'h07, 1, 1, 0, 1, 0);
    drive_bit(1'b1, 16);
    n = exp_q.size();
    wait_frames(n, ok);
    tests++;
    if (!ok || got_q.size() != n) begin
      fails++;
      $display("FAIL parity_count: got %0d pulses expected %0d", got_q.size(), n);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL parity_frame: got d=%h fe=%b pe=%b expected d=%h fe=%b pe=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    int n; bit ok; logic [9:0] e, g;
    ce_div = 1;
    send_frame(8'h00, 0, 0, 0, 1, 0);
    send_frame(8'hFF, 0, 0, 0, 1, 0);
    drive_bit(1'b1, 16);
    n = exp_q.size();
    wait_frames(n, ok);
    tests++;
    if (!ok || got_q.size() != n) begin
      fails++;
      $display("FAIL b2b_count: got %0d pulses expected %0d", got_q.size(), n);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL b2b_frame: got d=%h fe=%b pe=%b expected d=%h fe=%b pe=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int n; bit ok; logic [9:0] e, g; logic [7:0] d;
    ce_div = 4;
    d = 8'h3C;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 16);
    drive_bit(d[4], 8);
    tests++;
    if (bus.rx_busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_busy_before: got %b expected 1", bus.rx_busy);
    end
    #2 reset = 1'b1;
    bus.ser_in = 1'b1;
    #1;
    tests++;
    if ({bus.rx_data, bus.new_rx_data, bus.frame_err, bus.parity_err, bus.rx_busy} !== 12'h000) begin
      fails++;
      $display("FAIL rst_mid_async: got %h expected 000",
               {bus.rx_data, bus.new_rx_data, bus.frame_err, bus.parity_err, bus.rx_busy});
    end
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    wait_ticks(40);
    tests++;
    if (got_q.size() != 0 || bus.rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_quiet: got pulses=%0d busy=%b expected pulses=0 busy=0", got_q.size(), bus.rx_busy);
    end
    send_frame(8'h96, 0, 0, 0, 1, 0);
    drive_bit(1'b1, 16);
    n = exp_q.size();
    wait_frames(n, ok);
    tests++;
    if (!ok || got_q.size() != n) begin
      fails++;
      $display("FAIL rst_mid_count: got %0d pulses expected %0d", got_q.size(), n);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL rst_mid_frame: got d=%h fe=%b pe=%b expected d=%h fe=%b pe=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    int n; bit ok; logic [9:0] e, g;
    logic [7:0] d; bit pen, podd, pbit, stop; int gap;
    for (int k = 0; k < 24; k++) begin
      ce_div = int'($urandom_range(4, 1));
      d    = 8'($urandom);
      pen  = 1'($urandom);
      podd = 1'($urandom);
      pbit = 1'($urandom);
      stop = ($urandom_range(7, 0) != 0);
      send_frame(d, pen, podd, pbit, stop, 1);
      gap = stop ? int'($urandom_range(8, 0)) : int'($urandom_range(10, 4));
      if (gap > 0) drive_bit(1'b1, gap);
    end
    drive_bit(1'b1, 24);
    n = exp_q.size();
    wait_frames(n, ok);
    tests++;
    if (!ok || got_q.size() != n) begin
      fails++;
      $display("FAIL random_count: got %0d pulses expected %0d", got_q.size(), n);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL random_frame: got d=%h fe=%b pe=%b expected d=%h fe=%b pe=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_false_start();
    test_framing_break();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
